// File: rtl/drp_regfile.sv
// DRP-style register file for a clock-synthesis block: a fixed-latency read/write
// port in front of per-channel divide registers, decoded into divide/multiply values.
module drp_regfile #(
  parameter int NUM_CH  = 7,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 1
) (
  input  logic                  DCLK,
  input  logic                  RST_N,
  input  logic                  DEN,
  input  logic                  DWE,
  input  logic [ADDR_W-1:0]     DADDR,
  input  logic [DATA_W-1:0]     DI,
  output logic [DATA_W-1:0]     DO,
  output logic                  DRDY,
  output logic                  DERR,
  output logic                  OVR,
  output logic                  CFG_UPD,
  output logic [7*NUM_CH-1:0]   CLKOUT_DIV,
  output logic [6:0]            CLKFB_MULT
);

  // Register i lives at address i: ClkReg1/2 pairs, then FB pair, DivReg, PowerReg.
  localparam int                NUM_REGS    = 2*NUM_CH + 4;
  localparam int                FB_IDX      = 2*NUM_CH;
  localparam logic [DATA_W-1:0] CLKREG1_RST = DATA_W'(16'h0041);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   daddr_q;
  logic                dwe_q;
  logic [DATA_W-1:0]   di_q;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic                hit;
  logic [DATA_W-1:0]   rd_data;
  logic                last_busy;
  logic                commit_wr;

  // NOTE: every always_comb output gets a default before any conditional, so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (daddr_q == ADDR_W'(i)) begin
        hit     = 1'b1;
        rd_data = regs[i];
      end
    end
  end

  assign last_busy = (state == BUSY) && (cnt == 4'd0);
  assign commit_wr = last_busy && dwe_q && hit;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      daddr_q <= '0;
      dwe_q   <= 1'b0;
      di_q    <= '0;
      DRDY    <= 1'b0;
      DERR    <= 1'b0;
      CFG_UPD <= 1'b0;
      OVR     <= 1'b0;
      DO      <= '0;
    end else begin
      DRDY    <= 1'b0;
      DERR    <= 1'b0;
      CFG_UPD <= 1'b0;
      case (state)
        IDLE: begin
          if (DEN) begin
            daddr_q <= DADDR;
            dwe_q   <= DWE;
            di_q    <= DI;
            cnt     <= 4'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          // A request while busy is dropped; the captured access is left untouched.
          if (DEN) OVR <= 1'b1;
          if (cnt == 4'd0) begin
            state   <= IDLE;
            DRDY    <= 1'b1;
            DERR    <= ~hit;
            CFG_UPD <= dwe_q & hit;
            if (!dwe_q) DO <= hit ? rd_data : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: this small register array is reset explicitly; the clock outputs must be valid out of reset.
  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= ((i % 2 == 0) && (i < FB_IDX + 2)) ? CLKREG1_RST : '0;
    end else if (commit_wr) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (daddr_q == ADDR_W'(i)) regs[i] <= di_q;
    end
  end

  // No-count bypasses the counter entirely; otherwise high + low phase times.
  function automatic logic [6:0] div_of(input logic [11:0] r1, input logic no_count);
    return no_count ? 7'd1 : ({1'b0, r1[11:6]} + {1'b0, r1[5:0]});
  endfunction

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign CLKOUT_DIV[7*k +: 7] = div_of(regs[2*k][11:0], regs[2*k+1][6]);
  end

  assign CLKFB_MULT = div_of(regs[FB_IDX][11:0], regs[FB_IDX+1][6]);

endmodule

// File: tb/tb_drp_regfile.sv
// Directed bench for drp_regfile: one instance at LATENCY=3 for the main features,
// a second at LATENCY=4 for the reset-abort case.
module tb_drp_regfile;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: NUM_CH=7, ADDR_W=7, DATA_W=16, LATENCY=3
  logic        rst_n_a;
  logic        den, dwe;
  logic [6:0]  daddr;
  logic [15:0] di, dout;
  logic        drdy, derr, ovr, cfg_upd;
  logic [48:0] clkout_div;
  logic [6:0]  clkfb_mult;

  drp_regfile #(.NUM_CH(7), .ADDR_W(7), .DATA_W(16), .LATENCY(3)) dut (
    .DCLK(clk), .RST_N(rst_n_a), .DEN(den), .DWE(dwe), .DADDR(daddr), .DI(di),
    .DO(dout), .DRDY(drdy), .DERR(derr), .OVR(ovr), .CFG_UPD(cfg_upd),
    .CLKOUT_DIV(clkout_div), .CLKFB_MULT(clkfb_mult)
  );

  // Instance B: LATENCY=4
  logic        rst_n_b;
  logic        b_den, b_dwe;
  logic [6:0]  b_daddr;
  logic [15:0] b_di, b_dout;
  logic        b_drdy, b_derr, b_ovr, b_cfg_upd;
  logic [48:0] b_clkout_div;
  logic [6:0]  b_clkfb_mult;

  drp_regfile #(.NUM_CH(7), .ADDR_W(7), .DATA_W(16), .LATENCY(4)) dut4 (
    .DCLK(clk), .RST_N(rst_n_b), .DEN(b_den), .DWE(b_dwe), .DADDR(b_daddr), .DI(b_di),
    .DO(b_dout), .DRDY(b_drdy), .DERR(b_derr), .OVR(b_ovr), .CFG_UPD(b_cfg_upd),
    .CLKOUT_DIV(b_clkout_div), .CLKFB_MULT(b_clkfb_mult)
  );

  // Called just after a falling edge; drives one request and returns at the falling
  // edge where DRDY is seen. lat = cycles from the sampling edge, -1 on timeout.
  task automatic access(input logic we, input logic [6:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rdo,
                        output logic rerr, output logic rupd);
    den = 1'b1; dwe = we; daddr = a; di = d;
    @(negedge clk);
    den = 1'b0; dwe = 1'b0; di = '0;
    lat = -1; rdo = '0; rerr = 1'b0; rupd = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (drdy) begin
        lat = c; rdo = dout; rerr = derr; rupd = cfg_upd;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [48:0] exp_div;
    for (int k = 0; k < 7; k++) exp_div[7*k +: 7] = 7'd2;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    den = 0; dwe = 0; daddr = 0; di = 0;
    b_den = 0; b_dwe = 0; b_daddr = 0; b_di = 0;
    repeat (3) @(negedge clk);
    n_vec++; if (drdy !== 1'b0)     begin n_err++; $display("FAIL rst_drdy got %b want 0", drdy); end
    n_vec++; if (derr !== 1'b0)     begin n_err++; $display("FAIL rst_derr got %b want 0", derr); end
    n_vec++; if (ovr !== 1'b0)      begin n_err++; $display("FAIL rst_ovr got %b want 0", ovr); end
    n_vec++; if (cfg_upd !== 1'b0)  begin n_err++; $display("FAIL rst_cfg_upd got %b want 0", cfg_upd); end
    n_vec++; if (dout !== 16'h0000) begin n_err++; $display("FAIL rst_do got %h want 0000", dout); end
    n_vec++; if (clkout_div !== exp_div) begin n_err++; $display("FAIL rst_clkout_div got %h want %h", clkout_div, exp_div); end
    n_vec++; if (clkfb_mult !== 7'd2) begin n_err++; $display("FAIL rst_clkfb_mult got %0d want 2", clkfb_mult); end
    rst_n_a = 1'b1; rst_n_b = 1'b1;
  endtask

  // First request is driven in the same cycle reset is released.
  task automatic test_read_default;
    int lat; logic [15:0] rdo; logic e, u;
    access(1'b0, 7'd0, 16'h0, lat, rdo, e, u);
    n_vec++; if (lat !== 3)          begin n_err++; $display("FAIL rd0_latency got %0d want 3", lat); end
    n_vec++; if (rdo !== 16'h0041)   begin n_err++; $display("FAIL rd0_do got %h want 0041", rdo); end
    n_vec++; if (e !== 1'b0 || u !== 1'b0) begin n_err++; $display("FAIL rd0_flags got derr=%b upd=%b want 0 0", e, u); end
    n_vec++; if (clkout_div[6:0] !== 7'd2) begin n_err++; $display("FAIL rd0_div0 got %0d want 2", clkout_div[6:0]); end
    @(negedge clk);
    n_vec++; if (drdy !== 1'b0)      begin n_err++; $display("FAIL drdy_width got %b want 0", drdy); end
  endtask

  task automatic test_write_div;
    int lat; logic [15:0] rdo; logic e, u;
    access(1'b1, 7'd2, 16'h0103, lat, rdo, e, u);
    n_vec++; if (lat !== 3)          begin n_err++; $display("FAIL wr2_latency got %0d want 3", lat); end
    n_vec++; if (u !== 1'b1 || e !== 1'b0) begin n_err++; $display("FAIL wr2_flags got upd=%b derr=%b want 1 0", u, e); end
    n_vec++; if (dout !== 16'h0041)  begin n_err++; $display("FAIL wr2_do_held got %h want 0041", dout); end
    n_vec++; if (clkout_div[13:7] !== 7'd7) begin n_err++; $display("FAIL wr2_div1 got %0d want 7", clkout_div[13:7]); end
    @(negedge clk);
    access(1'b0, 7'd2, 16'h0, lat, rdo, e, u);
    n_vec++; if (rdo !== 16'h0103 || u !== 1'b0) begin n_err++; $display("FAIL rd2_readback got %h upd=%b want 0103 0", rdo, u); end
  endtask

  task automatic test_nocount;
    int lat; logic [15:0] rdo; logic e, u;
    @(negedge clk);
    access(1'b1, 7'd1, 16'h0040, lat, rdo, e, u);
    n_vec++; if (clkout_div[6:0] !== 7'd1) begin n_err++; $display("FAIL nocnt_div0 got %0d want 1", clkout_div[6:0]); end
    @(negedge clk);
    access(1'b1, 7'd0, 16'h0FFF, lat, rdo, e, u);
    n_vec++; if (clkout_div[6:0] !== 7'd1) begin n_err++; $display("FAIL nocnt_div0_r1chg got %0d want 1", clkout_div[6:0]); end
    @(negedge clk);
    access(1'b1, 7'd1, 16'h0000, lat, rdo, e, u);
    n_vec++; if (clkout_div[6:0] !== 7'd126) begin n_err++; $display("FAIL max_div0 got %0d want 126", clkout_div[6:0]); end
  endtask

  task automatic test_fb_and_storage;
    int lat; logic [15:0] rdo; logic e, u;
    @(negedge clk);
    access(1'b1, 7'd14, 16'h0145, lat, rdo, e, u);
    n_vec++; if (clkfb_mult !== 7'd10) begin n_err++; $display("FAIL fb_mult got %0d want 10", clkfb_mult); end
    @(negedge clk);
    access(1'b1, 7'd15, 16'h0040, lat, rdo, e, u);
    n_vec++; if (clkfb_mult !== 7'd1) begin n_err++; $display("FAIL fb_nocnt got %0d want 1", clkfb_mult); end
    @(negedge clk);
    access(1'b1, 7'd17, 16'hBEEF, lat, rdo, e, u);
    @(negedge clk);
    access(1'b0, 7'd17, 16'h0, lat, rdo, e, u);
    n_vec++; if (rdo !== 16'hBEEF || e !== 1'b0) begin n_err++; $display("FAIL power_readback got %h derr=%b want beef 0", rdo, e); end
  endtask

  task automatic test_unmapped;
    int lat; logic [15:0] rdo; logic e, u;
    logic [48:0] div_before;
    @(negedge clk);
    access(1'b0, 7'd18, 16'h0, lat, rdo, e, u);
    n_vec++; if (lat !== 3 || e !== 1'b1) begin n_err++; $display("FAIL unmap_rd got lat=%0d derr=%b want 3 1", lat, e); end
    n_vec++; if (rdo !== 16'h0000)   begin n_err++; $display("FAIL unmap_rd_do got %h want 0000", rdo); end
    n_vec++; if (ovr !== 1'b0)       begin n_err++; $display("FAIL unmap_ovr got %b want 0", ovr); end
    div_before = clkout_div;
    @(negedge clk);
    access(1'b1, 7'd127, 16'hFFFF, lat, rdo, e, u);
    n_vec++; if (e !== 1'b1 || u !== 1'b0) begin n_err++; $display("FAIL unmap_wr got derr=%b upd=%b want 1 0", e, u); end
    n_vec++; if (clkout_div !== div_before) begin n_err++; $display("FAIL unmap_wr_div got %h want %h", clkout_div, div_before); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] rdo; logic e, u;
    @(negedge clk);
    access(1'b0, 7'd2, 16'h0, lat, rdo, e, u);
    access(1'b0, 7'd14, 16'h0, lat, rdo, e, u);
    n_vec++; if (lat !== 3 || rdo !== 16'h0145) begin n_err++; $display("FAIL b2b got lat=%0d do=%h want 3 0145", lat, rdo); end
    n_vec++; if (ovr !== 1'b0)       begin n_err++; $display("FAIL b2b_ovr got %b want 0", ovr); end
  endtask

  task automatic test_overrun;
    int pulses; logic [15:0] seen_do; logic seen_err;
    pulses = 0; seen_do = '0; seen_err = 1'b0;
    @(negedge clk);
    den = 1'b1; dwe = 1'b0; daddr = 7'd2; di = 16'h0;
    @(negedge clk);
    den = 1'b1; dwe = 1'b1; daddr = 7'd18; di = 16'hFFFF;
    @(negedge clk);
    den = 1'b0; dwe = 1'b0; daddr = 7'd0; di = 16'h0;
    if (drdy) pulses++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (drdy) begin pulses++; seen_do = dout; seen_err = derr; end
    end
    n_vec++; if (pulses !== 1)       begin n_err++; $display("FAIL ovr_pulses got %0d want 1", pulses); end
    n_vec++; if (seen_do !== 16'h0103 || seen_err !== 1'b0) begin n_err++; $display("FAIL ovr_capture got do=%h derr=%b want 0103 0", seen_do, seen_err); end
    n_vec++; if (ovr !== 1'b1)       begin n_err++; $display("FAIL ovr_set got %b want 1", ovr); end
    n_vec++; if (clkout_div[13:7] !== 7'd7) begin n_err++; $display("FAIL ovr_no_write got %0d want 7", clkout_div[13:7]); end
    rst_n_a = 1'b0;
    #1;
    n_vec++; if (ovr !== 1'b0)       begin n_err++; $display("FAIL ovr_clear got %b want 0", ovr); end
    @(negedge clk);
    rst_n_a = 1'b1;
  endtask

  task automatic test_reset_abort;
    int pulses; int lat;
    pulses = 0; lat = -1;
    @(negedge clk);
    b_den = 1'b1; b_dwe = 1'b1; b_daddr = 7'd0; b_di = 16'h0FFF;
    @(negedge clk);
    b_den = 1'b0; b_dwe = 1'b0; b_di = 16'h0;
    @(negedge clk);
    rst_n_b = 1'b0;
    #1;
    n_vec++; if (b_drdy !== 1'b0)    begin n_err++; $display("FAIL abort_drdy_rst got %b want 0", b_drdy); end
    @(negedge clk);
    rst_n_b = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b_drdy) pulses++;
    end
    n_vec++; if (pulses !== 0)       begin n_err++; $display("FAIL abort_no_drdy got %0d want 0", pulses); end
    n_vec++; if (b_clkout_div[6:0] !== 7'd2) begin n_err++; $display("FAIL abort_div0 got %0d want 2", b_clkout_div[6:0]); end
    b_den = 1'b1; b_dwe = 1'b0; b_daddr = 7'd0;
    @(negedge clk);
    b_den = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b_drdy) begin lat = c; break; end
    end
    n_vec++; if (lat !== 4 || b_dout !== 16'h0041) begin n_err++; $display("FAIL abort_readback got lat=%0d do=%h want 4 0041", lat, b_dout); end
  endtask

  initial begin
    test_reset;
    test_read_default;
    test_write_div;
    test_nocount;
    test_fb_and_storage;
    test_unmapped;
    test_back_to_back;
    test_overrun;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/drp_regfile.md
DRP_REGFILE -- requirements
Module: drp_regfile

Interface
REQ-001 SHALL provide parameter NUM_CH, default 7; number of output-clock channels (1..16).
REQ-002 SHALL provide parameter ADDR_W, default 7; DADDR width; 2*NUM_CH+4 <= 2**ADDR_W.
REQ-003 SHALL provide parameter DATA_W, default 16; DI/DO width (>= 16).
REQ-004 SHALL provide parameter LATENCY, default 1; cycles from accepted DEN to DRDY (1..15).
REQ-005 SHALL provide port DCLK, input, 1 bit; single clock, rising edge.
REQ-006 SHALL provide port RST_N, input, 1 bit; reset, asynchronous, active-low.
REQ-007 SHALL provide port DEN, input, 1 bit; access request strobe.
REQ-008 SHALL provide port DWE, input, 1 bit; 1 = write, 0 = read, sampled with DEN.
REQ-009 SHALL provide port DADDR, input, ADDR_W bits; register address.
REQ-010 SHALL provide port DI, input, DATA_W bits; write data.
REQ-011 SHALL provide port DO, output, DATA_W bits; read data, valid while DRDY = 1.
REQ-012 SHALL provide port DRDY, output, 1 bit; one-cycle completion pulse.
REQ-013 SHALL provide port DERR, output, 1 bit; high with DRDY when the address was unmapped.
REQ-014 SHALL provide port OVR, output, 1 bit; sticky, DEN seen while busy.
REQ-015 SHALL provide port CFG_UPD, output, 1 bit; one-cycle pulse, a mapped write committed.
REQ-016 SHALL provide port CLKOUT_DIV, output, 7*NUM_CH bits; channel k divide value at bits [7k+6:7k].
REQ-017 SHALL provide port CLKFB_MULT, output, 7 bits; feedback multiply value.

Function
REQ-018 SHALL map addresses: 2k = ClkReg1[k], 2k+1 = ClkReg2[k] (k < NUM_CH); 2*NUM_CH = ClkReg1_FB; 2*NUM_CH+1 = ClkReg2_FB; 2*NUM_CH+2 = DivReg; 2*NUM_CH+3 = PowerReg; all others unmapped.
REQ-019 SHALL implement FSM IDLE -> BUSY -> IDLE; DEN in IDLE captures DADDR/DWE/DI and loads down-counter with LATENCY-1; with LATENCY=1, BUSY lasts one cycle.
REQ-020 SHALL, in the last BUSY cycle (counter = 0), commit write or load DO, assert DRDY for exactly that cycle, and return to IDLE on the next edge.
REQ-021 SHALL make DRDY rise exactly LATENCY cycles after the DCLK edge that sampled DEN.
REQ-022 SHALL hold DO until the next read completes; writes and unmapped accesses do not change DO except as below.
REQ-023 SHALL, for unmapped reads, drive DO = 0 and DERR = 1 with DRDY; unmapped writes modify nothing, DERR = 1, CFG_UPD = 0.
REQ-024 SHALL ignore DEN during BUSY (captured fields unchanged) and set OVR = 1 until reset.
REQ-025 SHALL accept DEN in the IDLE cycle following DRDY (back-to-back accesses every LATENCY+1 cycles).
REQ-026 SHALL pulse CFG_UPD in the same cycle as DRDY for a mapped write only.
REQ-027 SHALL compute channel k divide = 1 when ClkReg2[k][6] = 1 (no-count), else ClkReg1[k][11:6] + ClkReg1[k][5:0] as 7-bit unsigned sum.
REQ-028 SHALL compute CLKFB_MULT identically from ClkReg1_FB / ClkReg2_FB.
REQ-029 SHALL drive CLKOUT_DIV and CLKFB_MULT combinationally from the registers, updating the cycle after commit.
REQ-030 SHALL store full DATA_W bits of each mapped register; reads return the written value unmodified.

Reset
REQ-031 SHALL, while RST_N = 0, force FSM to IDLE, counter 0, DRDY = 0, DERR = 0, CFG_UPD = 0, OVR = 0, DO = 0.
REQ-032 SHALL reset every ClkReg1 (incl. FB) to 16'h0041 (divide 2), every ClkReg2, DivReg, PowerReg to 0.
REQ-033 SHALL abort an in-flight access on reset: no commit, no DRDY after release.
REQ-034 SHALL accept DEN on the first DCLK edge after RST_N deasserts.

Verification
REQ-035 SHALL verify: after reset, read addr 0 -> DRDY after LATENCY cycles, DO = 16'h0041, CLKOUT_DIV[6:0] = 2.
REQ-036 SHALL verify: write addr 2 DI = 16'h0103 (high 4, low 3), LATENCY=3 -> DRDY and CFG_UPD on cycle 3, CLKOUT_DIV[13:7] = 7, read-back 16'h0103.
REQ-037 SHALL verify: write ClkReg2[0] = 16'h0040 -> CLKOUT_DIV[6:0] = 1 regardless of ClkReg1[0].
REQ-038 SHALL verify: read addr 2*NUM_CH+4 -> DRDY = 1, DERR = 1, DO = 0; OVR stays 0.
REQ-039 SHALL verify: second DEN during BUSY -> ignored, single DRDY, OVR = 1 until RST_N = 0.
REQ-040 SHALL verify: RST_N low mid-write (LATENCY=4, cycle 2) -> no DRDY, target register holds reset value.
